// File: rtl/rv32i_pkg.sv
// Shared rv32i core definitions: XLEN, the canonical NOP encoding and the
// instruction-fetch FSM state type.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// rv32i instruction-fetch front end: owns the PC, issues one imem read at a time and hands words to decode.
// Optional IFETCH_MISALIGN_CHECK_EN traps misaligned redirects in a FAULT state instead of masking pc[1:0].
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus_4
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] redirect_target;
  logic            redirect_ok;
  logic            req_fire;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redirect_ok     = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_target = redirect_pc;
`else
  assign redirect_ok     = redirect_valid;
  assign redirect_target = redirect_pc & ~32'h0000_0003;
`endif

  // A request is held back while a stale response is still owed, keeping one read in flight.
  assign imem_req_valid = (state_q == REQ) && !discard_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_ok) pc_d = redirect_target;
      end
      REQ: begin
        if (imem_rsp_valid) discard_d = 1'b0;
        if (redirect_ok) pc_d = redirect_target;
        if (req_fire) begin
          state_d = WAIT;
          if (redirect_ok) discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (discard_q || redirect_valid) begin
            discard_d = 1'b0;
            state_d   = REQ;
            if (redirect_ok) pc_d = redirect_target;
          end else begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            state_d    = HOLD;
          end
        end else if (redirect_ok) begin
          pc_d      = redirect_target;
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_ok) begin
          pc_d    = redirect_target;
          state_d = REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      FAULT: begin
        if (imem_rsp_valid) discard_d = 1'b0;
        if (redirect_ok) begin
          pc_d    = redirect_target;
          state_d = REQ;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef IFETCH_MISALIGN_CHECK_EN
    // Misaligned target: park in FAULT, remembering whether a read is still owed so it gets dropped.
    if (redirect_valid && !redirect_ok) begin
      state_d = FAULT;
      pc_d    = pc_q;
      case (state_q)
        REQ:     discard_d = req_fire || (discard_q && !imem_rsp_valid);
        WAIT:    discard_d = !imem_rsp_valid;
        FAULT:   discard_d = discard_q && !imem_rsp_valid;
        default: discard_d = 1'b0;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      if_instr_q <= RV32I_NOP;
      if_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_valid     = (state_q == HOLD);
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_pc_plus_4 = if_pc_q + 32'd4;
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign fetch_misalign = (state_q == FAULT);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural single-outstanding imem of selectable latency.
// Define IFETCH_MISALIGN_CHECK_EN for both DUT and bench to exercise the misalignment trap.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int checkCount = 0;
  int errorCount = 0;

  int          memLatency = 1;
  logic        memPending = 1'b0;
  logic [31:0] memPendAddr = '0;
  int          memCount = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus_4   (if_pc_plus_4)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a simple address-derived pattern.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a + 32'h1000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic redirV, input logic [31:0] redirPc, input logic ready);
    redirect_valid = redirV;
    redirect_pc    = redirPc;
    if_ready       = ready;
  endtask

  // One clock: capture acceptance before the edge, then drive the memory response 1ns after it.
  task automatic stepCycle();
    if (imem_req_valid && imem_req_ready) begin
      memPending  = 1'b1;
      memPendAddr = imem_addr;
      memCount    = memLatency;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (memPending) begin
      memCount--;
      if (memCount == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memWord(memPendAddr);
        memPending     = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'h0000_0013);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_addr", imem_addr, 32'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
    checkOutput("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
`endif
    rst_n = 1'b1;
    checkOutput("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    stepCycle();

    $display("[TB] streaming fetch, 1-cycle memory");
    for (int i = 0; i < 3; i++) begin
      checkOutput("seq_req_valid", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("seq_addr", imem_addr, 32'(i * 4));
      stepCycle();
      checkOutput("seq_wait_if_valid", {31'd0, if_valid}, 32'd0);
      stepCycle();
      checkOutput("seq_if_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("seq_if_instr", if_instr, memWord(32'(i * 4)));
      checkOutput("seq_if_pc", if_pc, 32'(i * 4));
      checkOutput("seq_if_pc4", if_pc_plus_4, 32'(i * 4 + 4));
      stepCycle();
    end

    $display("[TB] decode stall in HOLD");
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("stall_addr_pre", imem_addr, 32'h0000_000C);
    stepCycle();
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_if_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("stall_if_instr", if_instr, memWord(32'h0000_000C));
      checkOutput("stall_if_pc", if_pc, 32'h0000_000C);
      checkOutput("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      stepCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    stepCycle();
    checkOutput("stall_release_req", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("stall_release_addr", imem_addr, 32'h0000_0010);

    $display("[TB] redirect while waiting on memory");
    memLatency = 2;
    stepCycle();
    checkOutput("wredir_in_wait", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wredir_rsp_now", {31'd0, imem_rsp_valid}, 32'd1);
    checkOutput("wredir_if_valid", {31'd0, if_valid}, 32'd0);
    stepCycle();
    memLatency = 1;
    checkOutput("wredir_drop_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("wredir_instr_kept", if_instr, memWord(32'h0000_000C));
    checkOutput("wredir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("wredir_addr", imem_addr, 32'h0000_0100);

    $display("[TB] redirect beats if_ready in HOLD");
    stepCycle();
    stepCycle();
    checkOutput("hredir_if_pc", if_pc, 32'h0000_0100);
    checkOutput("hredir_if_instr", if_instr, memWord(32'h0000_0100));
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("hredir_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("hredir_addr", imem_addr, 32'h0000_0200);

    $display("[TB] wrap at top of address space");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    stepCycle();
    checkOutput("wrap_dropped_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    stepCycle();
    stepCycle();
    checkOutput("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_if_pc4", if_pc_plus_4, 32'h0000_0000);
    checkOutput("wrap_if_instr", if_instr, memWord(32'hFFFF_FFFC));
    stepCycle();
    checkOutput("wrap_next_addr", imem_addr, 32'h0000_0000);
    checkOutput("wrap_next_req", {31'd0, imem_req_valid}, 32'd1);

`ifdef IFETCH_MISALIGN_CHECK_EN
    $display("[TB] misaligned redirect trap");
    applyStimulus(1'b1, 32'h0000_0102, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    checkOutput("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("mis_if_valid", {31'd0, if_valid}, 32'd0);
    stepCycle();
    checkOutput("mis_still_no_req", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0104, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mis_clear", {31'd0, fetch_misalign}, 32'd0);
    checkOutput("mis_addr", imem_addr, 32'h0000_0104);
    checkOutput("mis_req", {31'd0, imem_req_valid}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("mis_if_pc", if_pc, 32'h0000_0104);
    checkOutput("mis_if_instr", if_instr, memWord(32'h0000_0104));
    stepCycle();
`else
    $display("[TB] misaligned redirect is masked");
    applyStimulus(1'b1, 32'h0000_0102, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("mask_addr", imem_addr, 32'h0000_0100);
    checkOutput("mask_req", {31'd0, imem_req_valid}, 32'd1);
`endif

    $display("[TB] asynchronous reset from HOLD");
    applyStimulus(1'b0, 32'h0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("arst_pre_if_valid", {31'd0, if_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("arst_if_instr", if_instr, 32'h0000_0013);
    checkOutput("arst_if_pc", if_pc, 32'h0);
    checkOutput("arst_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
